// File: rtl/ccip_mmio_requester.sv
// ccip_mmio_requester
// Host-side CCI-P MMIO initiator. It takes one command at a time on a
// valid/ready handshake and turns it into a single-cycle MMIO write or read
// request toward an AFU. It then matches the returning c2 read response by tid,
// enforces a response timeout, and presents a result on a valid/ready handshake.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready only while idle)
//   cmd_write                1 = write, 0 = read
//   cmd_addr                 dword address; bit 0 set = misaligned (error, no bus op)
//   cmd_wdata                write data
//   mmio_wr_valid/rd_valid   one-cycle request pulses (rx.c0.mmioWrValid/RdValid)
//   mmio_address/length/tid  request header; length is always 2'b01 (64-bit)
//   mmio_data                write data (c0 data[63:0])
//   rsp_valid/rsp_tid/data   AFU read response (tx.c2)
//   res_valid/res_ready      result handshake
//   res_data                 read data (0 for writes and errors)
//   res_err                  timeout or misaligned address
//   stray_rsp                one-cycle pulse after a response that matched nothing
//
// Optional build macro MMIO_REQ_STATS_EN: adds saturating 32-bit counters
// stat_rd_cnt, stat_wr_cnt, stat_timeout_cnt and stat_stray_cnt.

module ccip_mmio_requester #(
    parameter int TID_W          = 9,
    parameter int TIMEOUT_CYCLES = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [15:0]      cmd_addr,
    input  logic [63:0]      cmd_wdata,
    output logic             mmio_wr_valid,
    output logic             mmio_rd_valid,
    output logic [15:0]      mmio_address,
    output logic [1:0]       mmio_length,
    output logic [TID_W-1:0] mmio_tid,
    output logic [63:0]      mmio_data,
    input  logic             rsp_valid,
    input  logic [TID_W-1:0] rsp_tid,
    input  logic [63:0]      rsp_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [63:0]      res_data,
    output logic             res_err,
    output logic             stray_rsp
`ifdef MMIO_REQ_STATS_EN
    ,
    output logic [31:0]      stat_rd_cnt,
    output logic [31:0]      stat_wr_cnt,
    output logic [31:0]      stat_timeout_cnt,
    output logic [31:0]      stat_stray_cnt
`endif
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, RESULT} state_t;

    state_t           state_reg;
    logic [TID_W-1:0] tid_cnt_reg;
    logic [TO_W-1:0]  to_cnt_reg;
    logic             req_write_reg;

    logic accept;
    logic rsp_match;
    logic to_expire;

    assign accept    = cmd_valid && cmd_ready;
    // mmio_tid holds the tid of the outstanding read while in WAIT_RSP.
    assign rsp_match = (state_reg == WAIT_RSP) && rsp_valid && (rsp_tid == mmio_tid);
    assign to_expire = (state_reg == WAIT_RSP) && (to_cnt_reg == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            tid_cnt_reg   <= '0;
            to_cnt_reg    <= '0;
            req_write_reg <= 1'b0;
            cmd_ready     <= 1'b0;
            mmio_wr_valid <= 1'b0;
            mmio_rd_valid <= 1'b0;
            mmio_address  <= '0;
            mmio_length   <= 2'b01;
            mmio_tid      <= '0;
            mmio_data     <= '0;
            res_valid     <= 1'b0;
            res_data      <= '0;
            res_err       <= 1'b0;
            stray_rsp     <= 1'b0;
        end else begin
            mmio_wr_valid <= 1'b0;
            mmio_rd_valid <= 1'b0;
            mmio_length   <= 2'b01;
            // Anything that is not the awaited response is reported, including
            // responses in other states and late ones after a timeout.
            stray_rsp     <= rsp_valid && !rsp_match;

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        if (cmd_addr[0]) begin
                            state_reg <= RESULT;
                            res_valid <= 1'b1;
                            res_err   <= 1'b1;
                            res_data  <= '0;
                        end else begin
                            state_reg     <= REQ;
                            req_write_reg <= cmd_write;
                            mmio_address  <= cmd_addr;
                            mmio_tid      <= tid_cnt_reg;
                            mmio_data     <= cmd_wdata;
                            if (cmd_write) begin
                                mmio_wr_valid <= 1'b1;
                            end else begin
                                mmio_rd_valid <= 1'b1;
                                tid_cnt_reg   <= tid_cnt_reg + 1'b1;
                            end
                        end
                    end else begin
                        // Also raises ready on the first clock after reset release.
                        cmd_ready <= 1'b1;
                    end
                end
                REQ: begin
                    if (req_write_reg) begin
                        state_reg <= RESULT;
                        res_valid <= 1'b1;
                        res_err   <= 1'b0;
                        res_data  <= '0;
                    end else begin
                        state_reg  <= WAIT_RSP;
                        to_cnt_reg <= '0;
                    end
                end
                WAIT_RSP: begin
                    // A match takes priority over a simultaneous timeout.
                    if (rsp_match) begin
                        state_reg <= RESULT;
                        res_valid <= 1'b1;
                        res_err   <= 1'b0;
                        res_data  <= rsp_data;
                    end else if (to_expire) begin
                        state_reg <= RESULT;
                        res_valid <= 1'b1;
                        res_err   <= 1'b1;
                        res_data  <= '0;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        state_reg <= IDLE;
                        cmd_ready <= 1'b1;
                        res_valid <= 1'b0;
                        res_err   <= 1'b0;
                        res_data  <= '0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef MMIO_REQ_STATS_EN
    logic [3:0] stat_inc;

    assign stat_inc[0] = accept && !cmd_addr[0] && !cmd_write;
    assign stat_inc[1] = accept && !cmd_addr[0] && cmd_write;
    assign stat_inc[2] = to_expire && !rsp_match;
    assign stat_inc[3] = rsp_valid && !rsp_match;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_stat
            logic [31:0] cnt_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (stat_inc[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
        end
    endgenerate

    assign stat_rd_cnt      = g_stat[0].cnt_reg;
    assign stat_wr_cnt      = g_stat[1].cnt_reg;
    assign stat_timeout_cnt = g_stat[2].cnt_reg;
    assign stat_stray_cnt   = g_stat[3].cnt_reg;
`endif

endmodule

// File: tb/tb_ccip_mmio_requester.sv
// Directed bench for ccip_mmio_requester. Expected requests and results are
// queued by the stimulus; a monitor pops and compares them whenever the DUT
// issues a request or completes a result handshake.

module tb_ccip_mmio_requester;
    localparam int TID_W = 9;
    localparam int TO    = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_write = 1'b0;
    logic [15:0]      cmd_addr = '0;
    logic [63:0]      cmd_wdata = '0;
    logic             mmio_wr_valid;
    logic             mmio_rd_valid;
    logic [15:0]      mmio_address;
    logic [1:0]       mmio_length;
    logic [TID_W-1:0] mmio_tid;
    logic [63:0]      mmio_data;
    logic             rsp_valid = 1'b0;
    logic [TID_W-1:0] rsp_tid = '0;
    logic [63:0]      rsp_data = '0;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [63:0]      res_data;
    logic             res_err;
    logic             stray_rsp;

    ccip_mmio_requester #(.TID_W(TID_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
        .mmio_address(mmio_address), .mmio_length(mmio_length),
        .mmio_tid(mmio_tid), .mmio_data(mmio_data),
        .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_err(res_err), .stray_rsp(stray_rsp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit               wr;
        logic [15:0]      addr;
        logic [TID_W-1:0] tid;
        logic [63:0]      data;
    } req_t;

    typedef struct {
        logic [63:0] data;
        logic        err;
    } res_t;

    req_t req_q[$];
    res_t res_q[$];
    req_t mon_req;
    res_t mon_res;

    int n_tests = 0;
    int n_fail  = 0;
    int stray_seen = 0;
    int stray_exp  = 0;
    int acc_cyc = 0;
    logic [TID_W-1:0] exp_tid = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (mmio_wr_valid || mmio_rd_valid) begin
                check("req_onehot", 64'(mmio_wr_valid & mmio_rd_valid), 64'd0);
                if (req_q.size() == 0) begin
                    check("req_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_req = req_q.pop_front();
                    check("req_kind", 64'(mmio_wr_valid), 64'(mon_req.wr));
                    check("req_addr", 64'(mmio_address), 64'(mon_req.addr));
                    check("req_tid", 64'(mmio_tid), 64'(mon_req.tid));
                    check("req_len", 64'(mmio_length), 64'd1);
                    if (mon_req.wr) check("req_data", mmio_data, mon_req.data);
                    $display("[TB] req %s addr=0x%04h tid=%0d", mon_req.wr ? "WR" : "RD",
                             mmio_address, mmio_tid);
                end
            end
            if (res_valid && res_ready) begin
                if (res_q.size() == 0) begin
                    check("res_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_res = res_q.pop_front();
                    check("res_data", res_data, mon_res.data);
                    check("res_err", 64'(res_err), 64'(mon_res.err));
                    $display("[TB] res data=0x%016h err=%0d", res_data, res_err);
                end
            end
            if (stray_rsp) stray_seen++;
        end
    end

    // Starts at the next posedge+1; returns at posedge+1 of cycle N+1.
    task automatic send_cmd(input bit w, input logic [15:0] a, input logic [63:0] d);
        int n;
        res_t rr;
        req_t rq;
        n = 0;
        @(posedge clk); #1;
        while (!cmd_ready) begin
            @(posedge clk); #1;
            n++;
            if (n > 200) begin
                check("cmd_ready_wait", 64'd0, 64'd1);
                return;
            end
        end
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        if (a[0]) begin
            rr.data = '0; rr.err = 1'b1; res_q.push_back(rr);
        end else begin
            rq.wr = w; rq.addr = a; rq.tid = exp_tid; rq.data = d;
            req_q.push_back(rq);
            if (w) begin
                rr.data = '0; rr.err = 1'b0; res_q.push_back(rr);
            end else begin
                exp_tid = exp_tid + 1'b1;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic send_rsp(input logic [TID_W-1:0] t, input logic [63:0] d);
        rsp_valid = 1'b1;
        rsp_tid   = t;
        rsp_data  = d;
        @(posedge clk); #1;
        rsp_valid = 1'b0;
    endtask

    // Waits for res_valid and checks its cycle offset from the accept cycle N.
    task automatic wait_res(input int exp_off, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!res_valid) begin
            n++;
            if (n > 100) begin
                check({name, "_noresult"}, 64'd0, 64'd1);
                return;
            end
            @(negedge clk);
        end
        check(name, 64'(cyc - acc_cyc + 1), 64'(exp_off));
    endtask

    task automatic do_read(input logic [15:0] a, input logic [63:0] d, input int delay);
        logic [TID_W-1:0] t;
        res_t rr;
        t = exp_tid;
        send_cmd(1'b0, a, 64'd0);
        repeat (delay) begin @(posedge clk); #1; end
        rr.data = d; rr.err = 1'b0; res_q.push_back(rr);
        send_rsp(t, d);
        wait_res(2 + delay, "rd_lat");
    endtask

    initial begin
        res_t rr;
        logic [TID_W-1:0] t;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_wr_valid", 64'(mmio_wr_valid), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_len", 64'(mmio_length), 64'd1);
        check("rst_addr", 64'(mmio_address), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

        // Write 0x0020
        send_cmd(1'b1, 16'h0020, 64'hDEAD_BEEF_0123_4567);
        @(negedge clk);
        check("wr_pulse", 64'(mmio_wr_valid), 64'd1);
        check("wr_res_early", 64'(res_valid), 64'd0);
        @(negedge clk);
        check("wr_pulse_end", 64'(mmio_wr_valid), 64'd0);
        check("wr_res_lat", 64'(res_valid), 64'd1);
        @(posedge clk); #1;
        check("wr_hdr_stable", 64'(mmio_address), 64'h0020);

        // Read with response after 3 cycles (tid 0)
        do_read(16'h0002, 64'hA5A5, 3);

        // Read with no response -> timeout, then late response is stray (tid 1)
        t = exp_tid;
        send_cmd(1'b0, 16'h0004, 64'd0);
        rr.data = '0; rr.err = 1'b1; res_q.push_back(rr);
        wait_res(2 + TO, "timeout_lat");
        @(posedge clk); #1;
        send_rsp(t, 64'h1234);
        stray_exp++;
        repeat (2) @(negedge clk);
        check("stray_late", 64'(stray_seen), 64'(stray_exp));

        // Advance to tid 5
        while (exp_tid != 5) do_read(16'h0010, 64'h100 + 64'(exp_tid), 1);

        // Wrong tid then right tid
        send_cmd(1'b0, 16'h0008, 64'd0);
        @(posedge clk); #1;
        send_rsp(9'd4, 64'hBAD);
        stray_exp++;
        rr.data = 64'hC0FFEE; rr.err = 1'b0; res_q.push_back(rr);
        send_rsp(9'd5, 64'hC0FFEE);
        wait_res(4, "wrong_tid_lat");
        repeat (2) @(negedge clk);
        check("stray_wrong_tid", 64'(stray_seen), 64'(stray_exp));

        // Back-pressure on the result
        res_ready = 1'b0;
        do_read(16'h000A, 64'h5555_AAAA_0000_FFFF, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            check("hold_valid", 64'(res_valid), 64'd1);
            check("hold_data", res_data, 64'h5555_AAAA_0000_FFFF);
            check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;

        // Misaligned read
        send_cmd(1'b0, 16'h0003, 64'd0);
        wait_res(1, "misaligned_lat");

        // 512 reads: tid wraps 511 -> 0
        for (int i = 0; i < 512; i++) do_read(16'h0040, {32'hD0D0_0000, 32'(i)}, 1);

        // Reset during WAIT_RSP
        t = exp_tid;
        send_cmd(1'b0, 16'h0020, 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("mid_rst_res_valid", 64'(res_valid), 64'd0);
        check("mid_rst_addr", 64'(mmio_address), 64'd0);
        check("mid_rst_tid", 64'(mmio_tid), 64'd0);
        check("mid_rst_len", 64'(mmio_length), 64'd1);
        res_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        send_rsp(t, 64'h7777);
        stray_exp++;
        exp_tid = '0;
        do_read(16'h0030, 64'h0BAD_F00D, 2);
        repeat (2) @(negedge clk);
        check("stray_after_rst", 64'(stray_seen), 64'(stray_exp));

        check("req_q_empty", 64'(req_q.size()), 64'd0);
        check("res_q_empty", 64'(res_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got 1, expected 0");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
